// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_ctrl transmitter
// between NREQ 4-phase req/ack character sources, with a send watchdog.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63,
  localparam int IW     = $clog2(NREQ),
  localparam int TW     = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] char_i,
  output logic [NREQ-1:0]   ack,
  output logic              timeout_o,
  output logic              busy,
  output logic [IW-1:0]     gnt_id,
  output logic [6:0]        wr,
  output logic              trx_req,
  input  logic              trx_ack
);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   last_gnt, last_n, gnt_n;
  logic [TW-1:0]   timer, timer_n;
  logic [NREQ-1:0] ack_n, elig, ack_set;
  logic [6:0]      wr_n, sel_char;
  logic            trx_req_n, timeout_n;
  logic            found, found_hi, req_g;
  logic [IW-1:0]   sel, sel_lo, sel_hi;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      trx_req   <= 1'b0;
      wr        <= '0;
      ack       <= '0;
      timeout_o <= 1'b0;
      gnt_id    <= '0;
      last_gnt  <= IW'(NREQ - 1);
      timer     <= '0;
    end else begin
      state     <= state_n;
      trx_req   <= trx_req_n;
      wr        <= wr_n;
      ack       <= ack_n;
      timeout_o <= timeout_n;
      gnt_id    <= gnt_n;
      last_gnt  <= last_n;
      timer     <= timer_n;
    end
  end

  assign busy = (state != IDLE);

  // Round robin: lowest eligible index above last_gnt, else lowest eligible overall.
  always_comb begin
    elig     = req & ~ack;
    found    = 1'b0;
    found_hi = 1'b0;
    sel_lo   = '0;
    sel_hi   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found  = 1'b1;
        sel_lo = IW'(i);
      end
      if (elig[i] && (i > int'(last_gnt))) begin
        found_hi = 1'b1;
        sel_hi   = IW'(i);
      end
    end
    sel      = found_hi ? sel_hi : sel_lo;
    sel_char = '0;
    req_g    = 1'b0;
    ack_set  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == sel)    sel_char = char_i[7*i +: 7];
      if (IW'(i) == gnt_id) req_g    = req[i];
      ack_set[i] = (IW'(i) == gnt_id);
    end
  end

  always_comb begin
    state_n   = state;
    trx_req_n = trx_req;
    wr_n      = wr;
    ack_n     = ack;
    timeout_n = 1'b0;
    gnt_n     = gnt_id;
    last_n    = last_gnt;
    timer_n   = timer;
    case (state)
      IDLE: begin
        // A stale trx_ack from an aborted frame blocks any new grant.
        if (!trx_ack && found) begin
          wr_n      = sel_char;
          gnt_n     = sel;
          trx_req_n = 1'b1;
          timer_n   = '0;
          state_n   = SEND;
        end
      end
      SEND: begin
        timer_n = (timer == TW'(TIMEOUT)) ? timer : timer + 1'b1;
        if (trx_ack) begin
          trx_req_n = 1'b0;
          ack_n     = ack_set;
          state_n   = RELEASE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          trx_req_n = 1'b0;
          ack_n     = ack_set;
          timeout_n = 1'b1;
          state_n   = RELEASE;
        end
      end
      RELEASE: begin
        if (!trx_ack && !req_g) begin
          ack_n   = '0;
          last_n  = gnt_id;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with a uart_ctrl
// stand-in, a per-cycle reference model and hand-computed expectations.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [7*N-1:0] char_i = '0;
  logic [N-1:0]  ack;
  logic          timeout_o, busy, trx_req;
  logic [1:0]    gnt_id;
  logic [6:0]    wr;
  logic          trx_ack = 1'b0;

  int total = 0;
  int bad = 0;

  uart_tx_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .clr_n(clr_n), .req(req), .char_i(char_i), .ack(ack),
    .timeout_o(timeout_o), .busy(busy), .gnt_id(gnt_id), .wr(wr),
    .trx_req(trx_req), .trx_ack(trx_ack)
  );

  always #5 clk = ~clk;

  // uart_ctrl stand-in: negedge-registered, start + 7 data + even parity + stop.
  logic       hold_ack = 1'b0;
  logic       mock_en = 1'b1;
  logic       active = 1'b0;
  logic       line = 1'b1;
  logic [3:0] bitn = '0;
  logic [9:0] sh = '0;
  logic [9:0] frame = '0;

  always @(negedge clk) begin
    if (hold_ack) begin
      trx_ack = 1'b1;
      active  = 1'b0;
    end else if (!trx_req) begin
      trx_ack = 1'b0;
      active  = 1'b0;
      line    = 1'b1;
    end else if (mock_en && !trx_ack) begin
      if (!active) begin
        active = 1'b1;
        sh     = {1'b1, ^wr, wr, 1'b0};
        bitn   = '0;
      end
      if (bitn < 4'd10) begin
        line        = sh[bitn];
        frame[bitn] = line;
        bitn++;
      end else if (bitn == 4'd10) begin
        line = 1'b1;
        bitn++;
      end else begin
        trx_ack = 1'b1;
        active  = 1'b0;
      end
    end
  end

  // Reference model: who owns the channel, whether the frame is still out, its age.
  logic       m_busy, m_send, m_tp;
  logic [1:0] m_owner, m_gnt, m_last, ix;
  logic [6:0] m_char;
  int         m_age;
  logic       m_found;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_busy = 0; m_send = 0; m_tp = 0; m_owner = 0; m_gnt = 0;
      m_last = 2'(N - 1); m_char = 0; m_age = 0;
    end else begin
      m_tp = 0;
      if (!m_busy) begin
        m_found = 0;
        if (!trx_ack) begin
          for (int k = 1; k <= N; k++) begin
            ix = 2'((int'(m_last) + k) % N);
            if (!m_found && req[ix]) begin
              m_found = 1; m_owner = ix; m_gnt = ix;
              m_char = char_i[7*ix +: 7];
              m_busy = 1; m_send = 1; m_age = 0;
            end
          end
        end
      end else if (m_send) begin
        m_age++;
        if (trx_ack) m_send = 0;
        else if (m_age == TO) begin m_send = 0; m_tp = 1; end
      end else if (!trx_ack && !req[m_owner]) begin
        m_busy = 0;
        m_last = m_owner;
      end
    end
  end

  int         glog_id[$];
  logic [6:0] glog_wr[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h required %0h", nm, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = '0;
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic wait_trx(input string nm);
    int n = 0;
    while (!trx_req && n < 20) begin @(negedge clk); n++; end
    chk(nm, trx_req, 1);
  endtask

  // Sources drop req on ack and, when rearm is set, re-raise it once ack falls.
  task automatic serve(input bit rearm, input int target, input string nm);
    int n = 0;
    while (n < 3000 && (glog_id.size() < target || (!rearm && (req != 0 || busy)))) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) req[i] = 1'b0;
        else if (rearm && !req[i] && !ack[i]) req[i] = 1'b1;
      end
    end
    chk({nm, "_done"}, n < 3000, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_time_limit reached at %0t", $time);
    $fatal(1);
  end

  initial begin
    int b, lat, hi, np, low, n;
    logic [N-1:0] ack_tp;
    logic prev = 1'b0;

    fork
      forever begin
        @(negedge clk);
        chk("cyc_trx_req", trx_req, m_busy && m_send);
        chk("cyc_wr", wr, m_char);
        chk("cyc_gnt_id", gnt_id, m_gnt);
        chk("cyc_busy", busy, m_busy);
        chk("cyc_timeout", timeout_o, m_tp);
        chk("cyc_ack", ack, (m_busy && !m_send) ? (4'b1 << m_owner) : 4'b0);
        if (trx_req && !prev) begin
          glog_id.push_back(int'(gnt_id));
          glog_wr.push_back(wr);
        end
        prev = trx_req;
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_trx_req", trx_req, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_wr", wr, 0);
    chk("rst_timeout", timeout_o, 0);
    @(negedge clk) clr_n = 1'b1;

    // single source, char 'h41
    @(negedge clk);
    char_i[6:0] = 7'h41;
    req[0] = 1'b1;
    @(posedge clk); #1;
    chk("t1_trx_req", trx_req, 1);
    chk("t1_wr", wr, 7'h41);
    chk("t1_gnt_id", gnt_id, 0);
    chk("t1_busy", busy, 1);
    lat = 0;
    while (!ack[0] && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("t1_ack_latency", lat, 12);
    chk("t1_frame", frame, 10'b1010000010);
    chk("t1_ack", ack, 4'b0001);
    @(negedge clk) req[0] = 1'b0;
    @(posedge clk); #1;
    chk("t1_ack_low", ack, 0);
    chk("t1_busy_low", busy, 0);

    // round robin with all four held
    do_reset();
    char_i = {7'h7F, 7'h2A, 7'h52, 7'h41};
    b = glog_id.size();
    req = 4'hF;
    serve(1, b + 5, "t2_rr");
    serve(0, 0, "t2_drain");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_gnt%0d", k), glog_id[b + k], k % N);
      chk($sformatf("t2_wr%0d", k), glog_wr[b + k], char_i[7*(k % N) +: 7]);
    end

    // priority rotation after a grant to 2
    do_reset();
    b = glog_id.size();
    req = 4'b0100;
    wait_trx("t3_first");
    repeat (2) @(negedge clk);
    req = req | 4'b1001;
    serve(0, 0, "t3_drain");
    chk("t3_gnt0", glog_id[b], 2);
    chk("t3_gnt1", glog_id[b + 1], 3);
    chk("t3_gnt2", glog_id[b + 2], 0);

    // watchdog with trx_ack tied low
    do_reset();
    mock_en = 1'b0;
    req = 4'b0010;
    hi = 0; np = 0; ack_tp = '0;
    repeat (40) begin
      @(negedge clk);
      if (trx_req) hi++;
      if (timeout_o) begin np++; ack_tp = ack; end
    end
    chk("t4_trx_req_cycles", hi, TO);
    chk("t4_pulse_count", np, 1);
    chk("t4_ack_at_pulse", ack_tp, 4'b0010);
    chk("t4_ack_held", ack, 4'b0010);
    @(negedge clk);
    req = '0;
    mock_en = 1'b1;
    @(posedge clk); #1;
    chk("t4_idle", busy, 0);

    // withdraw during SEND
    do_reset();
    char_i[13:7] = 7'h33;
    req = 4'b0010;
    wait_trx("t5_start");
    repeat (4) @(negedge clk);
    req[1] = 1'b0;
    low = 0; n = 0;
    while (!ack[1] && n < 100) begin
      @(negedge clk);
      n++;
      if (!trx_req && !ack[1]) low++;
    end
    chk("t5_trx_req_held", low, 0);
    chk("t5_ack", ack, 4'b0010);
    @(posedge clk); #1;
    chk("t5_ack_pulse_end", ack, 0);
    chk("t5_idle", busy, 0);

    // async reset mid-frame, then stale trx_ack blocks grants
    do_reset();
    char_i[6:0] = 7'h55;
    req = 4'b0001;
    wait_trx("t6_start");
    repeat (3) @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("t6_rst_trx_req", trx_req, 0);
    chk("t6_rst_ack", ack, 0);
    chk("t6_rst_busy", busy, 0);
    hold_ack = 1'b1;
    @(negedge clk);
    @(negedge clk) clr_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (trx_req || busy) n++;
    end
    chk("t6_no_grant_stale", n, 0);
    hold_ack = 1'b0;
    wait_trx("t6_grant_after");
    serve(0, 0, "t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
